transfer_pulse_sequencer: RTL

//  Generates the RT_n/WT_n/CT_n timing strobes and the twelve timepulses of a memory cycle time (MCT).

---
 rtl/transfer_pulse_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/transfer_pulse_sequencer.sv
// Memory-cycle timepulse sequencer: walks T01..T12 phase by phase, emits RT/WT/CT strobes,
// and schedules queued register transfers onto the write bus, one per timepulse.
module transfer_pulse_sequencer #(
    parameter int PHASES_PER_TP = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic        SIM_CLK,
    input  logic        SIM_RST,
    input  logic        MSTP,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [2:0]  REQ_SRC,
    input  logic [2:0]  REQ_DST,
    input  logic [3:0]  REQ_TP,
    output logic [11:0] TP_n,
    output logic        RT_n,
    output logic        WT_n,
    output logic        CT_n,
    output logic [7:0]  RSEL_n,
    output logic [7:0]  WSEL_n,
    output logic        MCT,
    output logic        ERR
);

    localparam int PW = $clog2(PHASES_PER_TP);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] PH_LAST = PW'(PHASES_PER_TP - 1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [2:0] src;
        logic [2:0] dst;
        logic [3:0] tp;
    } req_t;

    typedef enum logic {S_RUN, S_HOLD} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [3:0]    tp_q, tp_d;

    // Request queue
    req_t          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop;
    req_t          head;
    req_t          req_in;

    logic boundary, advance;
    logic head_valid, head_illegal, head_match, issue, err_set;

    logic [11:0] tp_n_d;
    logic [7:0]  rsel_d, wsel_d;
    logic        rt_d, wt_d, ct_d, mct_d, running;

    assign req_in     = '{src: REQ_SRC, dst: REQ_DST, tp: REQ_TP};
    assign REQ_READY  = (count != CNT_FULL);
    assign push       = REQ_VALID && REQ_READY;
    assign head       = mem[rd_ptr];
    assign head_valid = (count != '0);

    // Every timepulse boundary is the last phase; MSTP is only looked at there.
    assign boundary = (ph_q == PH_LAST);
    assign advance  = boundary && !MSTP;

    // State register
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state_q <= S_RUN;
            ph_q    <= PH_LAST;
            tp_q    <= 4'd12;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            tp_q    <= tp_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        tp_d    = tp_q;
        if (!boundary) begin
            state_d = S_RUN;
            ph_d    = ph_q + PW'(1);
        end else if (MSTP) begin
            state_d = S_HOLD;
        end else begin
            state_d = S_RUN;
            ph_d    = '0;
            tp_d    = (tp_q == 4'd12) ? 4'd1 : tp_q + 4'd1;
        end
    end

    // Issue decision, evaluated against the timepulse being entered
    always_comb begin
        head_illegal = (head.tp > 4'd12);
        head_match   = (head.tp == tp_d) || (head.tp == 4'd0);
        pop          = advance && head_valid && (head_illegal || head_match);
        issue        = advance && head_valid && !head_illegal && head_match;
        err_set      = advance && head_valid && head_illegal;
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        tp_n_d  = TP_n;
        rsel_d  = RSEL_n;
        wsel_d  = WSEL_n;
        running = (state_d == S_RUN);
        if (advance) begin
            tp_n_d = ~(12'd1 << (tp_d - 4'd1));
            rsel_d = '1;
            wsel_d = '1;
            if (issue) begin
                rsel_d[head.src] = 1'b0;
                wsel_d[head.dst] = 1'b0;
            end
        end else if (boundary) begin
            // Frozen: TP_n holds, selects drop
            rsel_d = '1;
            wsel_d = '1;
        end
        rt_d  = !(running && ph_d == PW'(1));
        wt_d  = !(running && ph_d == PW'(2));
        ct_d  = !(running && ph_d == PW'(3));
        mct_d = running && (tp_d == 4'd12) && (ph_d == PH_LAST);
    end

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            TP_n   <= '1;
            RT_n   <= 1'b1;
            WT_n   <= 1'b1;
            CT_n   <= 1'b1;
            RSEL_n <= '1;
            WSEL_n <= '1;
            MCT    <= 1'b0;
            ERR    <= 1'b0;
        end else begin
            TP_n   <= tp_n_d;
            RT_n   <= rt_d;
            WT_n   <= wt_d;
            CT_n   <= ct_d;
            RSEL_n <= rsel_d;
            WSEL_n <= wsel_d;
            MCT    <= mct_d;
            if (err_set) ERR <= 1'b1;
        end
    end

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage needs no reset; occupancy is tracked by count
    always_ff @(posedge SIM_CLK) begin
        if (push) mem[wr_ptr] <= req_in;
    end

endmodule
